// File: rtl/soc_pkg.sv
// Shared SoC definitions: data-port width codes, MMIO map and UART register layout.
// Imported by the memory-mapped peripherals sitting next to main_mem.
package soc_pkg;

  localparam logic [1:0] DW_BYTE = 2'd0;
  localparam logic [1:0] DW_HALF = 2'd1;
  localparam logic [1:0] DW_WORD = 2'd2;

  localparam logic [31:0] UART_BASE = 32'hFFFF_0000;

  localparam logic [31:0] UART_TXDATA = 32'h0000_0000;
  localparam logic [31:0] UART_STATUS = 32'h0000_0004;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; full/empty come from the pointer MSB compare.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage holds only data, so it is never cleared; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data port: TXDATA/STATUS window,
// transmit FIFO and bit-timing FSM. Status reads are combinational for the single-cycle core.
module mmio_uart_tx
  import soc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = UART_BASE,
  parameter int          CLK_HZ     = 12_500_000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  input  logic        DWE,
  input  logic [1:0]  DWidth,
  output logic [31:0] DRData,
  output logic        Sel,
  output logic        tx,
  output logic        TxBusy
);

  localparam int DIVISOR = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int DIV_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("mmio_uart_tx: CLK_HZ/BAUD gives a divisor below 2");
  end
  if (BASE_ADDR[2:0] != 3'b000) begin : g_bad_base
    $error("mmio_uart_tx: BASE_ADDR must be 8-byte aligned");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mmio_uart_tx: FIFO_DEPTH must be a power of two in 2..64");
  end

  function automatic logic [3:0] sat_count(input logic [CNT_W-1:0] c);
    logic [7:0] wide;
    wide = 8'(c);
    return (wide > 8'd15) ? 4'hF : wide[3:0];
  endfunction

  uart_state_t      state;
  uart_state_t      state_nxt;
  logic [DIV_W-1:0] baud_cnt;
  logic [DIV_W-1:0] baud_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       idx_nxt;
  logic [7:0]       shift_q;
  logic [7:0]       shift_nxt;
  logic             bit_end;

  logic             is_status;
  logic             wr_txdata;
  logic             wr_status;
  logic             ovf;
  logic [7:0]       status_byte;

  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Width code, byte offset within the word and upper store lanes do not affect this block.
  logic unused_bits;
  assign unused_bits = ^{DWidth, DAddr[1:0], DWData[31:8]};

  assign Sel       = (DAddr[31:3] == BASE_ADDR[31:3]);
  assign is_status = DAddr[2];
  assign wr_txdata = Sel & DWE & ~is_status;
  assign wr_status = Sel & DWE & is_status;
  assign TxBusy    = (state != IDLE) | ~fifo_empty;
  assign bit_end   = (baud_cnt == DIV_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .wdata (DWData[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A store that finds the FIFO full is lost even if a pop happens on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (wr_txdata && fifo_full) begin
      ovf <= 1'b1;
    end else if (wr_status) begin
      ovf <= 1'b0;
    end
  end

  always_comb begin
    status_byte                     = '0;
    status_byte[ST_FULL]            = fifo_full;
    status_byte[ST_EMPTY]           = fifo_empty;
    status_byte[ST_BUSY]            = TxBusy;
    status_byte[ST_OVF]             = ovf;
    status_byte[ST_CNT_LSB +: 4]    = sat_count(fifo_count);
  end

  assign DRData = (Sel && is_status) ? {24'b0, status_byte} : 32'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_nxt;
  end

  // tx is decoded from state so an asynchronous reset returns the line high at once.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift_q;
    fifo_pop  = 1'b0;
    tx        = 1'b1;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_nxt = fifo_rdata;
          baud_nxt  = '0;
          state_nxt = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) begin
          baud_nxt  = '0;
          idx_nxt   = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        tx = shift_q[0];
        if (bit_end) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift_q[7:1]};
          idx_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed-plus-random bench for mmio_uart_tx at DIVISOR=4: a line decoder recovers frames
// from tx and is compared against the byte queue the bench expects to see on the wire.
module tb_mmio_uart_tx;
  import soc_pkg::*;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          CLKHZ = 1000;
  localparam int          BAUDR = 250;
  localparam int          DEPTH = 8;
  localparam int          DIV   = (CLKHZ + BAUDR / 2) / BAUDR;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] DAddr;
  logic [31:0] DWData;
  logic        DWE;
  logic [1:0]  DWidth;
  logic [31:0] DRData;
  logic        Sel;
  logic        tx;
  logic        TxBusy;

  int n_cmp = 0;
  int n_mis = 0;
  int unsigned cyc = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic        stop_q[$];
  int unsigned st_q[$];

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .CLK_HZ     (CLKHZ),
    .BAUD       (BAUDR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .DAddr  (DAddr),
    .DWData (DWData),
    .DWE    (DWE),
    .DWidth (DWidth),
    .DRData (DRData),
    .Sel    (Sel),
    .tx     (tx),
    .TxBusy (TxBusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  // Line decoder: a falling edge from idle starts a frame; every bit is sampled mid-cell.
  initial begin
    logic [7:0]  b;
    logic        stp;
    logic        tx_prev;
    bit          aborted;
    int unsigned t0;
    int          k;
    tx_prev = 1'b1;
    stp     = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && tx_prev === 1'b1 && tx === 1'b0) begin
        t0      = cyc;
        aborted = 1'b0;
        b       = '0;
        for (int j = 1; j <= 9 * DIV + DIV / 2; j++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (j % DIV == DIV / 2) begin
            k = j / DIV;
            if (k >= 1 && k <= 8) b[k-1] = tx;
            if (k == 9) stp = tx;
          end
        end
        if (!aborted) begin
          rx_q.push_back(b);
          stop_q.push_back(stp);
          st_q.push_back(t0);
        end
      end
      tx_prev = tx;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Store on the data port; returns 1ns after the edge that sampled it.
  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] w);
    DAddr  = addr;
    DWData = data;
    DWidth = w;
    DWE    = 1'b1;
    @(posedge clk);
    #1;
    DWE    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic exp_sel,
                    input logic [31:0] exp_data);
    DAddr = addr;
    DWE   = 1'b0;
    #1;
    check({tag, "_sel"}, {31'b0, Sel}, {31'b0, exp_sel});
    check({tag, "_data"}, DRData, exp_data);
  endtask

  task automatic drain_check(input string tag);
    int n;
    n = 0;
    while (TxBusy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'b0, TxBusy}, 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
      check($sformatf("%s_stop%0d", tag, i), {31'b0, stop_q[i]}, 32'd1);
    end
    exp_q.delete();
    rx_q.delete();
    stop_q.delete();
  endtask

  initial begin
    logic [9:0] fr;
    logic [7:0] d [10];
    int         nb;

    reset  = 1'b1;
    DAddr  = 32'h0;
    DWData = 32'h0;
    DWE    = 1'b0;
    DWidth = DW_WORD;
    #1;
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, TxBusy}, 32'd0);
    rd("rst_nosel", 32'h0000_0004, 1'b0, 32'h0);
    rd("rst_status", BASE + UART_STATUS, 1'b1, 32'h02);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single byte: exact waveform and busy duration.
    bus_wr(BASE + UART_TXDATA, 32'h55, DW_BYTE);
    exp_q.push_back(8'h55);
    fr = {1'b1, 8'h55, 1'b0};
    @(negedge clk);
    check("single_lat_tx", {31'b0, tx}, 32'd1);
    check("single_lat_busy", {31'b0, TxBusy}, 32'd1);
    for (int c = 0; c < 10 * DIV; c++) begin
      @(negedge clk);
      check($sformatf("single_tx_c%0d", c), {31'b0, tx}, {31'b0, fr[c / DIV]});
      if (c == 10 * DIV - 1) check("single_busy_last", {31'b0, TxBusy}, 32'd1);
    end
    @(negedge clk);
    check("single_busy_fall", {31'b0, TxBusy}, 32'd0);
    check("single_tx_idle", {31'b0, tx}, 32'd1);
    drain_check("single");

    // Status during a frame: one byte in flight, two queued.
    for (int i = 0; i < 3; i++) begin
      d[i] = 8'($urandom);
      bus_wr(BASE + UART_TXDATA, {24'($urandom), d[i]}, DW_BYTE);
      exp_q.push_back(d[i]);
    end
    rd("stat_busy", BASE + UART_STATUS, 1'b1, 32'h24);
    rd("stat_lowbits", BASE + 32'd7, 1'b1, 32'h24);
    rd("txdata_read", BASE + UART_TXDATA, 1'b1, 32'h0);
    rd("outside_win", BASE + 32'd8, 1'b0, 32'h0);
    drain_check("status");

    // Overflow: one byte leaves for the shift register, DEPTH wait, the rest are lost.
    for (int i = 0; i < 10; i++) begin
      d[i] = 8'($urandom);
      bus_wr(BASE + UART_TXDATA, {24'h0, d[i]}, DW_BYTE);
      if (i <= DEPTH) exp_q.push_back(d[i]);
    end
    rd("ovf_status", BASE + UART_STATUS, 1'b1, 32'h8D);
    bus_wr(BASE + 32'd12, 32'h0, DW_WORD);
    rd("ovf_kept", BASE + UART_STATUS, 1'b1, 32'h8D);
    bus_wr(BASE + UART_STATUS, $urandom, DW_WORD);
    rd("ovf_cleared", BASE + UART_STATUS, 1'b1, 32'h85);
    drain_check("ovf");

    // Back-to-back frames: start bits 10*DIV+1 cycles apart.
    st_q.delete();
    bus_wr(BASE + UART_TXDATA, 32'hA5, DW_BYTE);
    bus_wr(BASE + UART_TXDATA, 32'h3C, DW_BYTE);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    drain_check("b2b");
    check("b2b_nstart", st_q.size(), 32'd2);
    if (st_q.size() == 2) check("b2b_gap", st_q[1] - st_q[0], 10 * DIV + 1);
    st_q.delete();

    // Widths and byte offsets: only lane 0 is sent.
    bus_wr(BASE + UART_TXDATA, 32'h1234_56C3, DW_WORD);
    bus_wr(BASE + 32'd2, 32'h0000_FFC3, DW_HALF);
    bus_wr(BASE + 32'd3, 32'hABCD_EFC3, DW_BYTE);
    repeat (3) exp_q.push_back(8'hC3);
    drain_check("width");

    // Stores outside the window do nothing.
    bus_wr(BASE + 32'd16, 32'h77, DW_BYTE);
    bus_wr(32'h0000_0000, 32'h77, DW_BYTE);
    rd("nosel_status", BASE + UART_STATUS, 1'b1, 32'h02);
    drain_check("nosel");

    // Random burst that always fits.
    nb = $urandom_range(1, DEPTH + 1);
    for (int i = 0; i < nb; i++) begin
      d[i] = 8'($urandom);
      bus_wr(BASE + UART_TXDATA, {24'($urandom), d[i]}, 2'($urandom_range(0, 2)));
      exp_q.push_back(d[i]);
    end
    drain_check("burst");

    // Asynchronous reset in the middle of a frame with bytes still queued.
    for (int i = 0; i < 3; i++) bus_wr(BASE + UART_TXDATA, 32'($urandom), DW_BYTE);
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_tx", {31'b0, tx}, 32'd1);
    check("arst_busy", {31'b0, TxBusy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (30 * DIV) begin
      @(negedge clk);
      if (tx !== 1'b1) check("arst_line_quiet", {31'b0, tx}, 32'd1);
    end
    rd("arst_status", BASE + UART_STATUS, 1'b1, 32'h02);
    drain_check("arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
